quad_decoder: RTL and testbench

- Quadrature encoder receiver. Turns raw A/B/index pins into the up/down step stream and position value, the counterpart to the team's up/down load counter.
- Sits between off-chip encoder pins and the control logic.
- Outputs both a position register and per-step up_not_down/step strobes, so an external up/down counter can be driven instead.

---
 rtl/qdec_pkg.sv | 19 +
 rtl/quad_decoder_if.sv | 33 +++
 rtl/qdec_sync.sv | 69 ++++++
 rtl/quad_decoder.sv | 111 +++++++++++
 tb/tb_quad_decoder.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/qdec_pkg.sv
// Purpose : shared encodings and defaults for the quadrature decoder.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package qdec_pkg;

   // Quadrature states {A,B}, listed in forward (up) rotation order.
   typedef enum logic [1:0] {
      Q00 = 2'b00,
      Q01 = 2'b01,
      Q11 = 2'b11,
      Q10 = 2'b10
   } qstate_e;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   localparam int FILTER_LEN_DEF = 4;

endpackage

// File: rtl/quad_decoder_if.sv
// Purpose : pin-side and control/status bundle of the quadrature decoder.
// Latency : n/a (wires only).
// Backpressure: none; all signals are level or single-cycle strobes.
// slave  = decoder side: takes encoder pins and controls, drives position/status.
// master = user side: drives encoder pins and controls, observes position/status.
interface quad_decoder_if #(
   parameter int WIDTH = 32
) ();

   logic             enc_a;
   logic             enc_b;
   logic             enc_idx;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             idx_clr_en;
   logic             err_clr;
   logic [WIDTH-1:0] position;
   logic             step;
   logic             up_not_down;
   logic             idx_seen;
   logic             err;

   modport slave (
      input  enc_a, enc_b, enc_idx, load, load_value, idx_clr_en, err_clr,
      output position, step, up_not_down, idx_seen, err
   );

   modport master (
      output enc_a, enc_b, enc_idx, load, load_value, idx_clr_en, err_clr,
      input  position, step, up_not_down, idx_seen, err
   );

endinterface

// File: rtl/qdec_sync.sv
// Purpose : 2-FF synchronizer for one asynchronous encoder pin, optional stability filter.
// Latency : 2 clk; 2 + FILTER_LEN clk when QDEC_GLITCH_FILTER_EN is defined.
// Backpressure: none; free-running sampler.
// Ports: clk, rst (async active-low), d_i raw pin, q_o synchronized (filtered) level.
// Build option: QDEC_GLITCH_FILTER_EN adds the FILTER_LEN-sample stability filter.
module qdec_sync #(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

`ifdef QDEC_GLITCH_FILTER_EN
   // cnt_q counts consecutive samples that disagree with the filtered level;
   // being a single bit, disagreeing samples are all the same new value.
   logic [3:0] cnt_q;
   logic [3:0] cnt_d;
   logic       filt_q;
   logic       filt_d;

   always_comb begin
      filt_d = filt_q;
      cnt_d  = 4'd0;
      if (s2_q != filt_q) begin
         if (cnt_q == 4'(FILTER_LEN - 1)) begin
            filt_d = s2_q;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= 4'd0;
         filt_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
      end
   end

   assign q_o = filt_q;
`else
   assign q_o = s2_q;
`endif

   generate
      if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_bad_filter_len
         $error("qdec_sync: FILTER_LEN must be within 2..15");
      end
   endgenerate

endmodule

// File: rtl/quad_decoder.sv
// Purpose : quadrature encoder receiver -> step/direction strobes and wrapping position.
// Latency : pin edge to step/position 3 clk (3 + FILTER_LEN with QDEC_GLITCH_FILTER_EN).
// Backpressure: none; every accepted transition is reported, position is always live.
// Ports: clk, rst (async active-low), bus (quad_decoder_if.slave: pins, load,
//        idx_clr_en, err_clr in; position, step, up_not_down, idx_seen, err out).
// Build option: QDEC_GLITCH_FILTER_EN enables the per-pin stability filter in qdec_sync.
module quad_decoder
   import qdec_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int FILTER_LEN = FILTER_LEN_DEF
) (
   input  logic           clk,
   input  logic           rst,
   quad_decoder_if.slave  bus
);

   logic a_s;
   logic b_s;
   logic idx_s;

   qdec_sync #(.FILTER_LEN(FILTER_LEN)) u_sync_a (
      .clk(clk), .rst(rst), .d_i(bus.enc_a), .q_o(a_s)
   );
   qdec_sync #(.FILTER_LEN(FILTER_LEN)) u_sync_b (
      .clk(clk), .rst(rst), .d_i(bus.enc_b), .q_o(b_s)
   );
   qdec_sync #(.FILTER_LEN(FILTER_LEN)) u_sync_idx (
      .clk(clk), .rst(rst), .d_i(bus.enc_idx), .q_o(idx_s)
   );

   logic [1:0]       s;
   logic [1:0]       sp_q;
   logic             idx_p_q;
   logic [WIDTH-1:0] pos_q,      pos_d;
   logic             step_q,     step_d;
   logic             dir_q,      dir_d;
   logic             idx_seen_q, idx_seen_d;
   logic             err_q,      err_d;
   logic             illegal;

   assign s = {a_s, b_s};

   always_comb begin
      step_d     = 1'b0;
      dir_d      = dir_q;
      illegal    = 1'b0;
      idx_seen_d = idx_s & ~idx_p_q;
      pos_d      = pos_q;

      case ({sp_q, s})
         {Q00, Q01}, {Q01, Q11}, {Q11, Q10}, {Q10, Q00}: begin
            step_d = 1'b1;
            dir_d  = DIR_UP;
         end
         {Q01, Q00}, {Q11, Q01}, {Q10, Q11}, {Q00, Q10}: begin
            step_d = 1'b1;
            dir_d  = DIR_DOWN;
         end
         {Q00, Q11}, {Q11, Q00}, {Q01, Q10}, {Q10, Q01}: begin
            illegal = 1'b1;
         end
         default: ;
      endcase

      // load beats index clear beats step; the step is still reported on step/up_not_down.
      if (bus.load) begin
         pos_d = bus.load_value;
      end else if (idx_seen_d && bus.idx_clr_en) begin
         pos_d = '0;
      end else if (step_d) begin
         pos_d = (dir_d == DIR_UP) ? pos_q + 1'b1 : pos_q - 1'b1;
      end

      // A new illegal transition outranks a simultaneous clear.
      if (illegal) begin
         err_d = 1'b1;
      end else if (bus.err_clr) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sp_q       <= 2'b00;
         idx_p_q    <= 1'b0;
         pos_q      <= '0;
         step_q     <= 1'b0;
         dir_q      <= DIR_UP;
         idx_seen_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         sp_q       <= s;
         idx_p_q    <= idx_s;
         pos_q      <= pos_d;
         step_q     <= step_d;
         dir_q      <= dir_d;
         idx_seen_q <= idx_seen_d;
         err_q      <= err_d;
      end
   end

   assign bus.position    = pos_q;
   assign bus.step        = step_q;
   assign bus.up_not_down = dir_q;
   assign bus.idx_seen    = idx_seen_q;
   assign bus.err         = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Purpose : self-checking bench for quad_decoder (directed vectors plus cycle model).
// Latency : n/a.
// Backpressure: n/a.
module tb_quad_decoder;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   quad_decoder_if #(.WIDTH(W)) bus ();

   quad_decoder #(.WIDTH(W), .FILTER_LEN(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;
   bit model_on  = 1'b0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Position of an {A,B} state around the Gray cycle 00,01,11,10.
   function automatic int gray_pos(input logic [1:0] ab);
      case (ab)
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   // Model: the decoder sees pins sampled two edges earlier and compares them
   // with the sample before that. Step direction is the Gray-cycle distance.
   logic [1:0]   ab_hist  [4];
   logic         idx_hist [4];
   logic [W-1:0] m_pos;
   logic         m_step, m_dir, m_idx, m_err;

   always begin
      int delta;
      @(posedge clk);
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin
            ab_hist[i]  = 2'b00;
            idx_hist[i] = 1'b0;
         end
         m_pos = '0; m_step = 1'b0; m_dir = 1'b1; m_idx = 1'b0; m_err = 1'b0;
      end else begin
         for (int i = 3; i > 0; i--) begin
            ab_hist[i]  = ab_hist[i-1];
            idx_hist[i] = idx_hist[i-1];
         end
         ab_hist[0]  = {bus.enc_a, bus.enc_b};
         idx_hist[0] = bus.enc_idx;
         delta  = (gray_pos(ab_hist[2]) - gray_pos(ab_hist[3]) + 4) % 4;
         m_step = (delta == 1) || (delta == 3);
         if (m_step) m_dir = (delta == 1);
         m_idx = idx_hist[2] && !idx_hist[3];
         if (bus.load)                   m_pos = bus.load_value;
         else if (m_idx && bus.idx_clr_en) m_pos = '0;
         else if (delta == 1)            m_pos = m_pos + 1;
         else if (delta == 3)            m_pos = m_pos - 1;
         if (delta == 2)       m_err = 1'b1;
         else if (bus.err_clr) m_err = 1'b0;
         #1;
         if (model_on && rst) begin
            chk("model position",    bus.position,    m_pos);
            chk("model step",        bus.step,        m_step);
            chk("model up_not_down", bus.up_not_down, m_dir);
            chk("model idx_seen",    bus.idx_seen,    m_idx);
            chk("model err",         bus.err,         m_err);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_ab(input logic [1:0] v);
      bus.enc_a = v[1];
      bus.enc_b = v[0];
   endtask

   // Drive a new A/B state on a negedge, check the step lands exactly 3 edges later.
   task automatic edge_check(input logic [1:0] v, input logic [W-1:0] exp_pos,
                             input logic exp_dir, input string nm);
      set_ab(v);
      tick(2);
      chk({nm, " early"}, bus.step, 1'b0);
      tick(1);
      chk({nm, " step"}, bus.step, 1'b1);
      chk({nm, " pos"},  bus.position, exp_pos);
      chk({nm, " dir"},  bus.up_not_down, exp_dir);
      tick(5);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      bus.enc_a = 1'b0; bus.enc_b = 1'b0; bus.enc_idx = 1'b0;
      bus.load = 1'b0; bus.load_value = '0; bus.idx_clr_en = 1'b0; bus.err_clr = 1'b0;
`ifndef QDEC_GLITCH_FILTER_EN
      model_on = 1'b1;
`endif
      tick(3);
      chk("rst position",    bus.position,    32'h0);
      chk("rst step",        bus.step,        1'b0);
      chk("rst up_not_down", bus.up_not_down, 1'b1);
      chk("rst idx_seen",    bus.idx_seen,    1'b0);
      chk("rst err",         bus.err,         1'b0);
      rst = 1'b1;
      tick(2);

`ifndef QDEC_GLITCH_FILTER_EN
      // forward rotation
      edge_check(2'b01, 32'd1, 1'b1, "fwd1");
      edge_check(2'b11, 32'd2, 1'b1, "fwd2");
      edge_check(2'b10, 32'd3, 1'b1, "fwd3");
      edge_check(2'b00, 32'd4, 1'b1, "fwd4");

      // reverse from reset, then wrap back up
      rst = 1'b0; tick(1); rst = 1'b1; tick(2);
      edge_check(2'b10, 32'hFFFF_FFFF, 1'b0, "rev");
      edge_check(2'b00, 32'h0,         1'b1, "wrap");

      // illegal 00->11
      set_ab(2'b11);
      tick(3);
      chk("ill err",  bus.err,      1'b1);
      chk("ill step", bus.step,     1'b0);
      chk("ill pos",  bus.position, 32'h0);
      tick(5);
      bus.err_clr = 1'b1; tick(1); bus.err_clr = 1'b0;
      chk("errclr", bus.err, 1'b0);

      // 11->01 down, then 01->10 illegal together with err_clr
      edge_check(2'b01, 32'hFFFF_FFFF, 1'b0, "dn");
      set_ab(2'b10);
      tick(2);
      bus.err_clr = 1'b1; tick(1); bus.err_clr = 1'b0;
      chk("set wins err", bus.err,      1'b1);
      chk("set wins pos", bus.position, 32'hFFFF_FFFF);
      tick(5);
      bus.err_clr = 1'b1; tick(1); bus.err_clr = 1'b0;
      chk("errclr2", bus.err, 1'b0);

      // load coinciding with an up step (10->00)
      set_ab(2'b00);
      tick(2);
      bus.load = 1'b1; bus.load_value = 32'h100;
      tick(1);
      bus.load = 1'b0;
      chk("load pos",  bus.position,    32'h100);
      chk("load step", bus.step,        1'b1);
      chk("load dir",  bus.up_not_down, 1'b1);
      tick(5);

      // index with clear enabled
      bus.idx_clr_en = 1'b1; bus.enc_idx = 1'b1;
      tick(3);
      chk("idxclr seen", bus.idx_seen, 1'b1);
      chk("idxclr pos",  bus.position, 32'h0);
      tick(1);
      chk("idx pulse", bus.idx_seen, 1'b0);
      bus.enc_idx = 1'b0;
      tick(4);

      // index with clear disabled
      edge_check(2'b01, 32'd1, 1'b1, "preidx");
      bus.idx_clr_en = 1'b0; bus.enc_idx = 1'b1;
      tick(3);
      chk("idx noclr seen", bus.idx_seen, 1'b1);
      chk("idx noclr pos",  bus.position, 32'd1);
      bus.enc_idx = 1'b0;
      tick(5);

      // rotate up to 7, then async reset between edges
      edge_check(2'b11, 32'd2, 1'b1, "r2");
      edge_check(2'b10, 32'd3, 1'b1, "r3");
      edge_check(2'b00, 32'd4, 1'b1, "r4");
      edge_check(2'b01, 32'd5, 1'b1, "r5");
      edge_check(2'b11, 32'd6, 1'b1, "r6");
      edge_check(2'b10, 32'd7, 1'b1, "r7");
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("arst pos",  bus.position,    32'h0);
      chk("arst step", bus.step,        1'b0);
      chk("arst dir",  bus.up_not_down, 1'b1);
      chk("arst idx",  bus.idx_seen,    1'b0);
      chk("arst err",  bus.err,         1'b0);
      set_ab(2'b00);
      tick(2);
      rst = 1'b1;
      tick(6);
      chk("release err", bus.err,      1'b0);
      chk("release pos", bus.position, 32'h0);
`else
      begin
         int glitch_steps = 0;
         int lat = 0;
         // 3-cycle glitch on A must be dropped
         bus.enc_a = 1'b1;
         tick(3);
         bus.enc_a = 1'b0;
         repeat (12) begin
            tick(1);
            if (bus.step) glitch_steps++;
         end
         chk("glitch steps", glitch_steps, 0);
         chk("glitch pos",   bus.position, 32'h0);
         // stable edge 00->10 (down) appears after 3 + FILTER_LEN cycles
         bus.enc_a = 1'b1;
         for (int i = 1; i <= 20 && lat == 0; i++) begin
            tick(1);
            if (bus.step) lat = i;
         end
         chk("filter latency", lat, 7);
         chk("filter pos",     bus.position,    32'hFFFF_FFFF);
         chk("filter dir",     bus.up_not_down, 1'b0);
         tick(1);
         chk("filter step once", bus.step, 1'b0);
         chk("filter err",       bus.err,  1'b0);
      end
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
